// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one two-cycle BRAM width-converter port between
// NUM_REQ requesters, with owner lock for atomic read-modify-write sequences.
module bram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ-1:0]            lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          busy_o,
    output logic                          locked_o,
    output logic                          err_o,
    output logic                          conv_en_o,
    output logic                          conv_we_o,
    output logic [ADDR_WIDTH-1:0]         conv_addr_o,
    output logic [DATA_WIDTH-1:0]         conv_din_o,
    input  logic [DATA_WIDTH-1:0]         conv_dout_i,
    input  logic                          conv_valid_i,
    input  logic                          conv_ready_i
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic             lock_hold_q, lock_hold_d;
    logic             pending_q, pending_d;

    logic [IDX_W-1:0]      win;
    logic                  found;
    logic                  issue;
    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Scan from rr_ptr upward with wrap; while locked only the owner may win.
    always_comb begin : pick_winner
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx] && (!lock_q || idx == owner_q)) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win) begin
                sel_we    = we_i[i];
                sel_lock  = lock_i[i];
                sel_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Qualifying with rst_ni keeps every output at 0 while reset is held.
    assign issue = rst_ni && (state_q == IDLE) && conv_ready_i && found;

    // A lock request takes effect at grant; a release is held back in
    // lock_hold_q until the releasing access leaves BUSY.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_hold_d = lock_hold_q;
        pending_d   = pending_q;
        if (state_q == BUSY) begin
            state_d   = IDLE;
            lock_d    = lock_hold_q;
            pending_d = 1'b0;
        end else if (issue) begin
            state_d     = BUSY;
            owner_d     = win;
            pending_d   = !sel_we;
            lock_d      = lock_q | sel_lock;
            lock_hold_d = sel_lock;
            if (!lock_q) begin
                rr_ptr_d = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_hold_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_hold_q <= lock_hold_d;
            pending_q   <= pending_d;
        end
    end

    // Converter data is valid only for a pending read in BUSY; any other
    // valid, or a missing one, is a protocol error.
    always_comb begin
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = '0;
        err_o       = 1'b0;
        conv_en_o   = 1'b0;
        conv_we_o   = 1'b0;
        conv_addr_o = '0;
        conv_din_o  = '0;
        if (issue) begin
            gnt_o[win]  = 1'b1;
            conv_en_o   = 1'b1;
            conv_we_o   = sel_we;
            conv_addr_o = sel_addr;
            conv_din_o  = sel_wdata;
        end
        if (rst_ni && state_q == BUSY) begin
            if (pending_q && conv_valid_i) begin
                rvalid_o[owner_q] = 1'b1;
                rdata_o           = conv_dout_i;
            end
            err_o = (pending_q != conv_valid_i);
        end else if (rst_ni && conv_valid_i) begin
            err_o = 1'b1;
        end
    end

    assign busy_o   = (state_q == BUSY);
    assign locked_o = lock_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: scripted cycle-by-cycle traffic, a simple
// converter model and per-requester read-data scoreboards.
module tb_bram_port_arbiter;
    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 32;

    logic                          clk_i;
    logic                          rst_ni;
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ-1:0]            lock_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          busy_o;
    logic                          locked_o;
    logic                          err_o;
    logic                          conv_en_o;
    logic                          conv_we_o;
    logic [ADDR_WIDTH-1:0]         conv_addr_o;
    logic [DATA_WIDTH-1:0]         conv_din_o;
    logic [DATA_WIDTH-1:0]         conv_dout_i;
    logic                          conv_valid_i;
    logic                          conv_ready_i;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_WIDTH-1:0] exp_q0[$];
    logic [DATA_WIDTH-1:0] exp_q1[$];

    int                    conv_mode = 0;
    logic                  cap_read  = 1'b0;
    logic                  cap_write = 1'b0;
    logic [ADDR_WIDTH-1:0] cap_addr  = '0;

    bram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .lock_i(lock_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .locked_o(locked_o), .err_o(err_o), .conv_en_o(conv_en_o),
        .conv_we_o(conv_we_o), .conv_addr_o(conv_addr_o),
        .conv_din_o(conv_din_o), .conv_dout_i(conv_dout_i),
        .conv_valid_i(conv_valid_i), .conv_ready_i(conv_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [DATA_WIDTH-1:0] conv_word(input logic [ADDR_WIDTH-1:0] a);
        return 32'hDEADBEEA + {25'd0, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic we, input logic lock,
                                 input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [DATA_WIDTH-1:0] wdata,
                                 input logic expect_data);
        req_i[r]  = 1'b1;
        we_i[r]   = we;
        lock_i[r] = lock;
        addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]  = addr;
        wdata_i[r*DATA_WIDTH +: DATA_WIDTH] = wdata;
        if (!we && expect_data) begin
            if (r == 0) exp_q0.push_back(conv_word(addr));
            else        exp_q1.push_back(conv_word(addr));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Converter model: an access seen at cycle T is answered at T+1; conv_mode
    // set in cycle T+1 can drop the answer or inject spurious valids.
    always @(negedge clk_i) begin
        cap_read  = conv_en_o && !conv_we_o;
        cap_write = conv_en_o && conv_we_o;
        cap_addr  = conv_addr_o;
    end

    always @(posedge clk_i) begin
        #2;
        conv_dout_i = cap_read ? conv_word(cap_addr) : '0;
        case (conv_mode)
            1:       conv_valid_i = 1'b0;
            2:       conv_valid_i = cap_write;
            3:       conv_valid_i = 1'b1;
            default: conv_valid_i = cap_read;
        endcase
    end

    // Read-data scoreboard: every rvalid must match the oldest expected word.
    always @(negedge clk_i) begin
        if (rvalid_o[0]) begin
            if (exp_q0.size() == 0) checkOutput("rvalid0_unexpected", 1, 0);
            else checkOutput("rdata_req0", rdata_o, exp_q0.pop_front());
        end
        if (rvalid_o[1]) begin
            if (exp_q1.size() == 0) checkOutput("rvalid1_unexpected", 1, 0);
            else checkOutput("rdata_req1", rdata_o, exp_q1.pop_front());
        end
    end

    initial begin
        rst_ni       = 1'b0;
        req_i        = 2'b11;
        we_i         = '0;
        lock_i       = '0;
        addr_i       = '0;
        wdata_i      = '0;
        conv_dout_i  = '0;
        conv_valid_i = 1'b0;
        conv_ready_i = 1'b1;

        // Reset state, with requests present
        @(negedge clk_i);
        checkOutput("rst_gnt", gnt_o, 0);
        checkOutput("rst_conv_en", conv_en_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_locked", locked_o, 0);
        checkOutput("rst_rvalid", rvalid_o, 0);
        checkOutput("rst_err", err_o, 0);
        next_cycle();
        req_i  = '0;
        rst_ni = 1'b1;
        next_cycle();

        // Single read by req0 at 0x05
        applyStimulus(0, 1'b0, 1'b0, 7'h05, '0, 1'b1);
        @(negedge clk_i);
        checkOutput("single_gnt", gnt_o, 2'b01);
        checkOutput("single_conv_en", conv_en_o, 1);
        checkOutput("single_conv_we", conv_we_o, 0);
        checkOutput("single_conv_addr", conv_addr_o, 7'h05);
        checkOutput("single_busy_t0", busy_o, 0);
        next_cycle();
        req_i = '0;
        @(negedge clk_i);
        checkOutput("single_rvalid", rvalid_o, 2'b01);
        checkOutput("single_rdata", rdata_o, 32'hDEADBEEF);
        checkOutput("single_busy_t1", busy_o, 1);
        checkOutput("single_gnt_t1", gnt_o, 0);
        checkOutput("single_err", err_o, 0);
        next_cycle();

        // Both held: rr_ptr is 1 after the req0 grant, so req1 leads
        applyStimulus(0, 1'b0, 1'b0, 7'h10, '0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 7'h21, '0, 1'b1);
        exp_q0.push_back(conv_word(7'h10));
        exp_q1.push_back(conv_word(7'h21));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checkOutput("rr_gnt", gnt_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            next_cycle();
            if (k == 3) req_i = '0;
            @(negedge clk_i);
            checkOutput("rr_busy_gnt", gnt_o, 0);
            checkOutput("rr_rvalid", rvalid_o, (k % 2 == 0) ? 2'b10 : 2'b01);
            next_cycle();
        end

        // conv_ready_i low stalls req1 for 3 cycles
        conv_ready_i = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 7'h33, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("stall_gnt", gnt_o, 0);
            checkOutput("stall_conv_en", conv_en_o, 0);
            checkOutput("stall_busy", busy_o, 0);
            next_cycle();
        end
        conv_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("stall_release_gnt", gnt_o, 2'b10);
        checkOutput("stall_release_addr", conv_addr_o, 7'h33);
        next_cycle();
        req_i = '0;
        @(negedge clk_i);
        checkOutput("stall_rvalid", rvalid_o, 2'b10);
        next_cycle();

        // Locked read-modify-write by req0 while req1 waits (rr_ptr is 0)
        applyStimulus(0, 1'b0, 1'b1, 7'h03, '0, 1'b1);
        applyStimulus(1, 1'b0, 1'b0, 7'h07, '0, 1'b1);
        @(negedge clk_i);
        checkOutput("lock_gnt1", gnt_o, 2'b01);
        checkOutput("lock_locked_t0", locked_o, 0);
        next_cycle();
        @(negedge clk_i);
        checkOutput("lock_locked_t1", locked_o, 1);
        checkOutput("lock_rvalid1", rvalid_o, 2'b01);
        next_cycle();
        applyStimulus(0, 1'b1, 1'b0, 7'h03, 32'hCAFEF00D, 1'b0);
        @(negedge clk_i);
        checkOutput("lock_gnt2", gnt_o, 2'b01);
        checkOutput("lock_conv_we", conv_we_o, 1);
        checkOutput("lock_conv_din", conv_din_o, 32'hCAFEF00D);
        checkOutput("lock_locked_t2", locked_o, 1);
        next_cycle();
        req_i[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("lock_locked_t3", locked_o, 1);
        checkOutput("lock_err_write", err_o, 0);
        next_cycle();
        @(negedge clk_i);
        checkOutput("lock_gnt3", gnt_o, 2'b10);
        checkOutput("lock_released", locked_o, 0);
        next_cycle();
        req_i = '0;
        @(negedge clk_i);
        checkOutput("lock_rvalid3", rvalid_o, 2'b10);
        next_cycle();

        // Read whose data never arrives
        applyStimulus(0, 1'b0, 1'b0, 7'h09, '0, 1'b0);
        @(negedge clk_i);
        checkOutput("drop_gnt", gnt_o, 2'b01);
        next_cycle();
        req_i     = '0;
        conv_mode = 1;
        @(negedge clk_i);
        checkOutput("drop_err", err_o, 1);
        checkOutput("drop_rvalid", rvalid_o, 0);
        next_cycle();
        conv_mode = 0;
        @(negedge clk_i);
        checkOutput("drop_err_pulse", err_o, 0);
        next_cycle();

        // Write answered with a spurious valid
        applyStimulus(1, 1'b1, 1'b0, 7'h0A, 32'h12345678, 1'b0);
        @(negedge clk_i);
        checkOutput("wr_gnt", gnt_o, 2'b10);
        next_cycle();
        req_i     = '0;
        conv_mode = 2;
        @(negedge clk_i);
        checkOutput("wr_valid_err", err_o, 1);
        checkOutput("wr_valid_rvalid", rvalid_o, 0);
        next_cycle();
        conv_mode = 0;
        @(negedge clk_i);
        checkOutput("wr_err_pulse", err_o, 0);
        next_cycle();

        // Valid while IDLE
        conv_mode = 3;
        @(negedge clk_i);
        checkOutput("idle_valid_err", err_o, 1);
        checkOutput("idle_valid_rvalid", rvalid_o, 0);
        next_cycle();
        conv_mode = 0;
        next_cycle();

        // Reset during BUSY of a locked read drops the data and the lock
        applyStimulus(0, 1'b0, 1'b1, 7'h11, '0, 1'b0);
        @(negedge clk_i);
        checkOutput("rstbusy_gnt", gnt_o, 2'b01);
        next_cycle();
        req_i  = '0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("rstbusy_busy", busy_o, 0);
        checkOutput("rstbusy_rvalid", rvalid_o, 0);
        checkOutput("rstbusy_rdata", rdata_o, 0);
        checkOutput("rstbusy_locked", locked_o, 0);
        checkOutput("rstbusy_err", err_o, 0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 7'h44, '0, 1'b1);
        @(negedge clk_i);
        checkOutput("post_rst_gnt", gnt_o, 2'b10);
        checkOutput("post_rst_locked", locked_o, 0);
        next_cycle();
        req_i = '0;
        @(negedge clk_i);
        checkOutput("post_rst_rvalid", rvalid_o, 2'b10);
        next_cycle();
        next_cycle();

        checkOutput("queue0_drained", exp_q0.size(), 0);
        checkOutput("queue1_drained", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter and sequencer that shares a single narrow-word BRAM width-converter port between NUM_REQ requesters, e.g. the register-programming path and the rule-checker lookup path of the IOPMP. It serialises the two-cycle converter accesses and routes read data back to the issuing requester. It also supports a lock for atomic read-modify-write sequences. Sits between the requesters and the BRAM width converter.

## Interface
- NUM_REQ, 2: number of requesters, ≥2.
- ADDR_WIDTH, 7: narrow-word address width at the converter port.
- DATA_WIDTH, 32: narrow-word data width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester access request; held with its payload until the matching gnt_o.
- we_i  in  NUM_REQ  1 = write, 0 = read.
- lock_i  in  NUM_REQ  1 = keep ownership after this access.
- addr_i  in  NUM_REQ×ADDR_WIDTH  word address per requester.
- wdata_i  in  NUM_REQ×DATA_WIDTH  write data per requester.
- gnt_o  out  NUM_REQ  one-hot grant; access issued this cycle.
- rvalid_o  out  NUM_REQ  one-hot read-data valid to the issuer.
- rdata_o  out  DATA_WIDTH  read data, shared, qualified by rvalid_o.
- busy_o  out  1  access in its second cycle.
- locked_o  out  1  arbiter locked to an owner.
- err_o  out  1  one-cycle pulse: converter protocol violation.
- conv_en_o, conv_we_o  out  1  converter enable and write enable.
- conv_addr_o  out  ADDR_WIDTH  converter address.
- conv_din_o  out  DATA_WIDTH  converter write data.
- conv_dout_i  in  DATA_WIDTH  converter read data.
- conv_valid_i  in  1  converter read data valid.
- conv_ready_i  in  1  converter can accept a new access.

## Operation
- FSM states: IDLE and BUSY. Registered state: owner index, rr_ptr, lock flag, read-pending flag.
- In IDLE with conv_ready_i=1 and any eligible req_i:
  - pick the winner w combinationally; gnt_o[w]=1.
  - conv_en_o=1; conv_we_o, conv_addr_o and conv_din_o are muxed from w. These outputs are 0 when no access is issued.
  - latch owner=w and pending = !we_i[w]; go to BUSY.
- Eligibility:
  - unlocked: all requesters. Winner is the first requesting index at or after rr_ptr, modulo NUM_REQ.
  - locked: only the owner; other requests stall without a grant.
- rr_ptr update: after each grant, rr_ptr = (w+1) mod NUM_REQ. rr_ptr is not updated while locked.
- Lock update on grant: lock flag = lock_i[w]. An owner access with lock_i=0 releases the lock at the end of that access.
- BUSY (always exactly 1 cycle, then IDLE):
  - busy_o=1; no grants.
  - If pending and conv_valid_i=1: rvalid_o[owner]=1 and rdata_o=conv_dout_i.
  - If pending and conv_valid_i=0: err_o=1 and no rvalid.
  - If not pending and conv_valid_i=1: err_o=1.
- In IDLE, conv_valid_i=1 gives err_o=1.
- IDLE with conv_ready_i=0: no grant and no state change.
- rdata_o is 0 when no rvalid_o bit is set.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr=0, lock=0, owner=0.
- Reset asserted mid-access clears BUSY and the lock immediately. The pending read is dropped, with no rvalid.
- Grant is combinational from req_i in the same cycle: zero cycles from request to issue when IDLE.
- Read latency: data arrives one cycle after gnt_o.
- Maximum throughput: one access every 2 cycles; back-to-back grants are at cycles T and T+2.
- Requests arriving during BUSY are evaluated in the next IDLE cycle.
- A requester dropping req_i before its grant is legal and is simply skipped.
- Worst-case wait when unlocked: 2·(NUM_REQ−1) cycles after becoming eligible.

## Test plan
- Single read by req0 at addr 0x05: gnt_o=01 at T; converter returns 0xDEADBEEF at T+1 -> rvalid_o=01, rdata_o=0xDEADBEEF, busy_o=1 at T+1.
- req0 and req1 both held continuously, reads: grants alternate 01,10,01,10 at T, T+2, T+4, T+6; each rvalid goes to the matching requester.
- Lock: req0 issues a read with lock_i=1 while req1 is requesting; then a write with lock_i=0 -> req1 is granted only at the third issue slot; locked_o=1 between the two req0 grants.
- conv_ready_i=0 held for 3 cycles with req1 pending -> no gnt_o and conv_en_o=0; grant occurs in the cycle conv_ready_i returns to 1.
- Protocol errors: read issued and conv_valid_i=0 at T+1 -> err_o pulse, no rvalid. A write followed by conv_valid_i=1 -> err_o pulse.
- rst_ni asserted in BUSY with a read pending -> all outputs 0 immediately; after release, req1 alone is granted first (rr_ptr=0 and req0 idle).
